// File: rtl/wb_regfile_if.sv
// wb_regfile_if: MEM/WB write-back bundle plus decode-stage read ports for
// wb_regfile. The master drives the write-back and read addresses; the
// register file (slave) returns read data, the write-back echo and the
// retire counter.
interface wb_regfile_if;
  logic [31:0] inResult;
  logic [31:0] inReadData;
  logic [4:0]  inRd;
  logic        inMemToReg;
  logic        inRegWrite;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [31:0] outRsData;
  logic [31:0] outRtData;
  logic [31:0] outWbData;
  logic [4:0]  outWbRd;
  logic        outWbValid;
  logic [31:0] retireCount;

  modport master (
    output inResult, inReadData, inRd, inMemToReg, inRegWrite, rs, rt,
    input  outRsData, outRtData, outWbData, outWbRd, outWbValid, retireCount
  );

  modport slave (
    input  inResult, inReadData, inRd, inMemToReg, inRegWrite, rs, rt,
    output outRsData, outRtData, outWbData, outWbRd, outWbValid, retireCount
  );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage and 31x32 register file (r0 hard-wired to 0).
// Two combinational read ports, one write port committed on the rising edge,
// a registered echo of the last write and a wrapping retire counter.
// Optional macro WB_REGFILE_BYPASS_EN forwards same-cycle write data to the
// read ports; without it reads always return pre-edge stored values.
module wb_regfile (
  input  logic        clock,
  input  logic        reset_n,
  wb_regfile_if.slave bus
);

  logic [31:0] wb_data;
  logic        commit;

  logic [31:0] regs_q [1:31];
  logic [31:0] regs_d [1:31];
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] retire_count_q, retire_count_d;

  logic [31:0] rs_stored, rt_stored;
  logic        rs_hit, rt_hit;

  // Write-back mux and commit qualifier; a write to r0 is never a commit.
  always_comb begin
    wb_data = bus.inMemToReg ? bus.inReadData : bus.inResult;
    commit  = bus.inRegWrite && (bus.inRd != 5'd0);
  end

  // Next-state for storage, write-back echo and retire counter.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    regs_d = regs_q;
    for (int i = 1; i < 32; i++) begin
      if (commit && (bus.inRd == 5'(i))) begin
        regs_d[i] = wb_data;
      end
    end
    wb_data_d      = wb_data;
    wb_rd_d        = bus.inRd;
    wb_valid_d     = commit;
    retire_count_d = retire_count_q + (commit ? 32'd1 : 32'd0);
  end

  // State registers, cleared asynchronously while reset_n is low.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the storage array is reset too, because reads must return 0 during and after reset.
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      wb_data_q      <= '0;
      wb_rd_q        <= '0;
      wb_valid_q     <= 1'b0;
      retire_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      regs_q         <= regs_d;
      wb_data_q      <= wb_data_d;
      wb_rd_q        <= wb_rd_d;
      wb_valid_q     <= wb_valid_d;
      retire_count_q <= retire_count_d;
    end
  end

  // Stored read values; address 0 falls through to the zero default.
  always_comb begin
    rs_stored = '0;
    rt_stored = '0;
    for (int i = 1; i < 32; i++) begin
      if (bus.rs == 5'(i)) rs_stored = regs_q[i];
      if (bus.rt == 5'(i)) rt_stored = regs_q[i];
    end
  end

`ifdef WB_REGFILE_BYPASS_EN
  // Write-through forwarding; blocked in reset so reads stay 0.
  always_comb begin
    rs_hit = reset_n && commit && (bus.inRd == bus.rs);
    rt_hit = reset_n && commit && (bus.inRd == bus.rt);
  end
`else
  // No forwarding: same-cycle hazards are stalled upstream.
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
  end
`endif

  // Read ports and registered outputs.
  always_comb begin
    bus.outRsData   = rs_hit ? wb_data : rs_stored;
    bus.outRtData   = rt_hit ? wb_data : rt_stored;
    bus.outWbData   = wb_data_q;
    bus.outWbRd     = wb_rd_q;
    bus.outWbValid  = wb_valid_q;
    bus.retireCount = retire_count_q;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed scoreboard bench for wb_regfile. Stimulus drives
// inputs on the falling edge and queues expected values; a monitor samples
// 3 time units later (before the next rising edge), popping the read/counter
// queue and, whenever outWbValid is high, the expected-commit queue.
module tb_wb_regfile;

`ifdef WB_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef enum logic [2:0] {S_RS, S_RT, S_CNT, S_VALID, S_WBRD, S_WBDATA} sel_e;

  typedef struct {
    string       name;
    sel_e        sel;
    logic [31:0] exp;
  } chk_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  logic clock;
  logic reset_n;
  wb_regfile_if bus ();

  chk_t chk_q[$];
  wb_t  wb_q[$];
  int   checks = 0;
  int   errors = 0;

  wb_regfile dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic expect_val(input string name, input sel_e sel, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  task automatic expect_wb(input logic [4:0] rd, input logic [31:0] data);
    wb_t w;
    w.rd   = rd;
    w.data = data;
    wb_q.push_back(w);
  endtask

  task automatic drive(input logic we, input logic [4:0] rd, input logic mtr,
                       input logic [31:0] res, input logic [31:0] rdata,
                       input logic [4:0] a, input logic [4:0] b);
    bus.inRegWrite = we;
    bus.inRd       = rd;
    bus.inMemToReg = mtr;
    bus.inResult   = res;
    bus.inReadData = rdata;
    bus.rs         = a;
    bus.rt         = b;
  endtask

  // Monitor: compare queued expectations against the sampled DUT outputs.
  initial begin
    forever begin
      chk_t        c;
      wb_t         w;
      logic [31:0] act;
      @(negedge clock);
      #3;
      if (bus.outWbValid === 1'b1) begin
        checks++;
        if (wb_q.size() == 0) begin
          errors++;
          $display("FAIL wb_unexpected: outWbRd=%0d outWbData=%h with no commit expected",
                   bus.outWbRd, bus.outWbData);
        end else begin
          w = wb_q.pop_front();
          if (bus.outWbRd !== w.rd || bus.outWbData !== w.data) begin
            errors++;
            $display("FAIL wb_echo: got rd=%0d data=%h, expected rd=%0d data=%h",
                     bus.outWbRd, bus.outWbData, w.rd, w.data);
          end
        end
      end
      while (chk_q.size() != 0) begin
        c = chk_q.pop_front();
        case (c.sel)
          S_RS:     act = bus.outRsData;
          S_RT:     act = bus.outRtData;
          S_CNT:    act = bus.retireCount;
          S_VALID:  act = {31'd0, bus.outWbValid};
          S_WBRD:   act = {27'd0, bus.outWbRd};
          default:  act = bus.outWbData;
        endcase
        checks++;
        if (act !== c.exp) begin
          errors++;
          $display("FAIL %s: got %h, expected %h", c.name, act, c.exp);
        end
      end
    end
  end

  // Stimulus: directed vectors with hand-computed expectations.
  initial begin
    reset_n = 1'b0;
    // Write attempted while in reset: must not commit at the first edge.
    drive(1'b1, 5'd4, 1'b0, 32'h0000_0055, 32'h0, 5'd5, 5'd31);

    @(negedge clock);
    expect_val("reset_rs", S_RS, 32'h0);
    expect_val("reset_rt", S_RT, 32'h0);
    expect_val("reset_cnt", S_CNT, 32'h0);
    expect_val("reset_valid", S_VALID, 32'h0);

    @(negedge clock);
    reset_n = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd4, 5'd0);
    expect_val("no_write_in_reset", S_RS, 32'h0);
    expect_val("cnt_after_reset", S_CNT, 32'h0);

    @(negedge clock);
    drive(1'b1, 5'd7, 1'b0, 32'hDEAD_BEEF, 32'h0BAD_0BAD, 5'd0, 5'd0);
    expect_wb(5'd7, 32'hDEAD_BEEF);

    @(negedge clock);
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd7, 5'd0);
    expect_val("write_read_r7", S_RS, 32'hDEAD_BEEF);
    expect_val("wb_rd_7", S_WBRD, 32'd7);
    expect_val("wb_valid_1", S_VALID, 32'd1);
    expect_val("cnt_1", S_CNT, 32'd1);

    @(negedge clock);
    drive(1'b1, 5'd3, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 5'd7, 5'd0);
    expect_wb(5'd3, 32'h1234_5678);
    expect_val("r7_kept", S_RS, 32'hDEAD_BEEF);

    @(negedge clock);
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd3, 5'd3);
    expect_val("memtoreg_rs", S_RS, 32'h1234_5678);
    expect_val("memtoreg_rt", S_RT, 32'h1234_5678);
    expect_val("cnt_2", S_CNT, 32'd2);

    @(negedge clock);
    drive(1'b1, 5'd0, 1'b0, 32'hAAAA_AAAA, 32'h0, 5'd0, 5'd0);
    expect_val("r0_same_cycle", S_RS, 32'h0);

    @(negedge clock);
    drive(1'b0, 5'd3, 1'b0, 32'hCAFE_F00D, 32'h0, 5'd0, 5'd3);
    expect_val("r0_reads_0", S_RS, 32'h0);
    expect_val("r0_cnt_same", S_CNT, 32'd2);
    expect_val("r0_valid_0", S_VALID, 32'h0);
    expect_val("ignore_no_we", S_RT, 32'h1234_5678);

    @(negedge clock);
    drive(1'b1, 5'd9, 1'b0, 32'h0000_0001, 32'h0, 5'd3, 5'd0);
    expect_wb(5'd9, 32'h1);
    expect_val("r3_unchanged", S_RS, 32'h1234_5678);

    @(negedge clock);
    drive(1'b1, 5'd9, 1'b0, 32'h0000_0002, 32'h0, 5'd9, 5'd9);
    expect_wb(5'd9, 32'h2);
    expect_val("bypass_rs", S_RS, BYP ? 32'h2 : 32'h1);
    expect_val("bypass_rt", S_RT, BYP ? 32'h2 : 32'h1);
    expect_val("cnt_3", S_CNT, 32'd3);

    @(negedge clock);
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd9, 5'd0);
    expect_val("r9_after", S_RS, 32'h2);
    expect_val("cnt_4", S_CNT, 32'd4);

    // Preload the counter to its maximum, then commit once to wrap it.
    @(negedge clock);
    force dut.retire_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_count_q;
    drive(1'b1, 5'd31, 1'b0, 32'h0000_0031, 32'h0, 5'd0, 5'd0);
    expect_wb(5'd31, 32'h31);
    expect_val("cnt_preload", S_CNT, 32'hFFFF_FFFF);

    @(negedge clock);
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd31, 5'd31);
    expect_val("cnt_wrap", S_CNT, 32'h0);
    expect_val("r31_read", S_RT, 32'h31);

    // Mid-cycle reset pulse: outputs clear without a clock edge.
    @(negedge clock);
    #1;
    reset_n = 1'b0;
    expect_val("areset_rs", S_RS, 32'h0);
    expect_val("areset_rt", S_RT, 32'h0);
    expect_val("areset_cnt", S_CNT, 32'h0);
    expect_val("areset_valid", S_VALID, 32'h0);
    expect_val("areset_wbrd", S_WBRD, 32'h0);
    expect_val("areset_wbdata", S_WBDATA, 32'h0);
    #3;
    reset_n = 1'b1;

    @(negedge clock);
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd31, 5'd7);
    expect_val("post_reset_r31", S_RS, 32'h0);
    expect_val("post_reset_r7", S_RT, 32'h0);

    @(negedge clock);
    drive(1'b1, 5'd1, 1'b0, 32'h0000_0011, 32'h0, 5'd0, 5'd0);
    expect_wb(5'd1, 32'h11);

    @(negedge clock);
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd1, 5'd0);
    expect_val("resume_r1", S_RS, 32'h11);
    expect_val("resume_cnt", S_CNT, 32'd1);

    // Drain both queues within a bounded number of cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      #4;
      if (chk_q.size() == 0 && wb_q.size() == 0) break;
    end
    checks++;
    if (chk_q.size() != 0 || wb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending checks=%0d commits=%0d, expected 0 and 0",
               chk_q.size(), wb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
